parity_fault_bist: RTL and testbench
====================================

// Module: parity_fault_bist
// PURPOSE
//  Clocked, parametrised stuck-at fault-injection BIST for a WIDTH-bit linear-chain parity generator.
//  - Sweeps all 2^WIDTH input patterns through a golden chain and a fault-injected copy, compares parity outputs.
//  - Reports detection, first detecting pattern, detecting-pattern count, or full-campaign fault coverage.
//  - Sits beside datapath parity logic as the self-test engine for the parity/fault-analysis flow.
// PARAMETERS
//  WIDTH  3  data bits, 2..8
//  ODD    0  0: even parity (P = ^d), 1: odd parity (P = ~^d)
//  (derived) NSITE = 2*WIDTH-1; SITEW = $clog2(NSITE); COVW = $clog2(2*NSITE+1)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         synchronous reset, active low
//  start      in   1         begin run; sampled only in IDLE
//  mode       in   1         0: single fault (site_sel/stuck_val), 1: campaign over all 2*NSITE faults
//  site_sel   in   SITEW     fault site, mode 0
//  stuck_val  in   1         stuck value, mode 0
//  fault_en   in   1         0: faulty copy equals golden (no injection)
//  busy       out  1         high in RUN
//  done       out  1         one-cycle pulse at end of run
//  err        out  1         site_sel >= NSITE at start (mode 0); held until next start
//  detected   out  1         mode 0: at least one pattern mismatched
//  first_pat  out  WIDTH     mode 0: lowest detecting pattern; 0 if none
//  det_count  out  WIDTH+1   mode 0: number of detecting patterns
//  cov_count  out  COVW      mode 1: number of faults detected by at least one pattern
//  pat_out    out  WIDTH     pattern currently applied
//  p_gold     out  1         golden parity of pat_out (combinational)
//  p_fault    out  1         faulty parity of pat_out (combinational)
// BEHAVIOUR
//  Clocking and reset
//  - Single clock clk. Reset is synchronous and active-low on rst_n.
//  - Reset: state=IDLE; busy, done, err, detected = 0; first_pat, det_count, cov_count, pat_out = 0.
//  Fault sites
//  - Sites 0..WIDTH-1: input bit d[i] (d[0] = LSB).
//  - Sites WIDTH..2*WIDTH-3: chain node w_k = d0^..^dk, k = 1..WIDTH-2.
//  - Site 2*WIDTH-2: parity output.
//  - A stuck node replaces its value for all downstream logic.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//  - IDLE, start=1, valid: clear results, pattern=0, fault index=0, go to RUN.
//  - IDLE, start=1, mode 0 with site_sel >= NSITE: set err=1, skip RUN, go to DONE.
//  - RUN: one pattern per cycle; start ignored.
//    - A mismatch updates detected, det_count, and first_pat (first_pat only if detected was 0).
//    - Mode 0: leave after pattern 2^WIDTH-1; RUN lasts 2^WIDTH cycles.
//    - Mode 1: faults ordered site-major, stuck-0 before stuck-1. Each fault gets 2^WIDTH cycles.
//      - Per-fault hit flag; cov_count increments at the last pattern of each fault if its hit flag is set.
//      - RUN lasts 2*NSITE*2^WIDTH cycles.
//  - DONE: done=1 for exactly one cycle, then IDLE.
//  Timing and holds
//  - Latency: start sampled at edge k -> done high in cycle k+2^W+1 (mode 0), k+2*NSITE*2^W+1 (mode 1).
//  - Results, err and pat_out hold in IDLE until the next accepted start.
//  - fault_en=0: detected=0, det_count=0, cov_count=0 after the full sweep.
//  - Counters use exact widths: pattern counter wraps at 2^WIDTH; det_count max 2^WIDTH, no overflow.
//  - rst_n low mid-RUN: abort next edge to the reset values; no done pulse.
// STRUCTURE
//  - Package parity_fault_pkg: NSITE/SITEW/COVW functions, site-kind decode (IN/NODE/OUT), state enum.
//  - Sub-module parity_chain_inj: combinational XOR chain with a single stuck-at injection port.
//    - Instantiated twice: golden copy with inject off, faulty copy under test.
// TESTING (WIDTH=3, ODD=0, NSITE=5)
//  - mode0 site0 stuck0 -> detected=1, first_pat=3'b001, det_count=4, done 9 cycles after start.
//  - mode0 site3 (w1) stuck1 -> detected=1, first_pat=3'b000, det_count=4.
//  - mode0 site4 (P) stuck0, fault_en=0 -> detected=0, det_count=0, first_pat=0.
//  - mode1 fault_en=1 -> cov_count=10, done 81 cycles after start; start pulses mid-run ignored.
//  - mode0 site_sel=5 -> err=1, done in cycle after start, busy never high.
//  - rst_n low at RUN cycle 4 -> next edge all outputs 0, state IDLE, no done; new start runs cleanly.

Source files
------------

// File: rtl/parity_fault_pkg.sv
// Shared types and sizing helpers for the parity fault-injection BIST.
// Site numbering: data inputs first, then internal chain nodes, then the parity output.
package parity_fault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SITE_IN,
    SITE_NODE,
    SITE_OUT
  } site_kind_e;

  function automatic int nsite(input int width);
    return 2 * width - 1;
  endfunction

  function automatic int site_w(input int width);
    return $clog2(nsite(width));
  endfunction

  function automatic int cov_w(input int width);
    return $clog2(2 * nsite(width) + 1);
  endfunction

  function automatic site_kind_e site_kind(input int site, input int width);
    if (site < width) begin
      return SITE_IN;
    end else if (site < 2 * width - 2) begin
      return SITE_NODE;
    end else begin
      return SITE_OUT;
    end
  endfunction

endpackage

// File: rtl/parity_chain_inj.sv
// Linear XOR parity chain with one optional stuck-at node.
// A stuck node overrides its value for everything downstream of it.
module parity_chain_inj
  import parity_fault_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int ODD   = 0,
  parameter int SITEW = 3
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             inj_en_i,
  input  logic [SITEW-1:0] inj_site_i,
  input  logic             inj_val_i,
  output logic             p_o
);

  site_kind_e       kindSel;
  logic [WIDTH-1:0] dEff;
  logic [WIDTH-1:0] chain;
  logic             par;

  assign kindSel = site_kind(int'(inj_site_i), WIDTH);

  // chain[k] is the running XOR of bits 0..k; nodes 1..WIDTH-2 are injectable.
  always_comb begin
    dEff  = d_i;
    chain = '0;
    par   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (inj_en_i && kindSel == SITE_IN && inj_site_i == SITEW'(i)) begin
        dEff[i] = inj_val_i;
      end
    end
    chain[0] = dEff[0];
    for (int k = 1; k < WIDTH; k++) begin
      chain[k] = chain[k-1] ^ dEff[k];
      if (k <= WIDTH - 2 && inj_en_i && kindSel == SITE_NODE &&
          inj_site_i == SITEW'(WIDTH + k - 1)) begin
        chain[k] = inj_val_i;
      end
    end
    par = (ODD != 0) ? ~chain[WIDTH-1] : chain[WIDTH-1];
    if (inj_en_i && kindSel == SITE_OUT) begin
      par = inj_val_i;
    end
  end

  assign p_o = par;

endmodule

// File: rtl/parity_fault_bist.sv
// Stuck-at fault-injection BIST: sweeps every input pattern through a golden and a faulty
// parity chain, reporting single-fault detection or campaign-wide fault coverage.
module parity_fault_bist
  import parity_fault_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int ODD   = 0,
  localparam int NSITE = nsite(WIDTH),
  localparam int SITEW = site_w(WIDTH),
  localparam int COVW  = cov_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [SITEW-1:0] site_sel,
  input  logic             stuck_val,
  input  logic             fault_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             detected,
  output logic [WIDTH-1:0] first_pat,
  output logic [WIDTH:0]   det_count,
  output logic [COVW-1:0]  cov_count,
  output logic [WIDTH-1:0] pat_out,
  output logic             p_gold,
  output logic             p_fault
);

  localparam int FIW = SITEW + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [FIW-1:0]   faultIdx_q, faultIdx_d;
  logic             hit_q, hit_d;
  logic             mode_q, mode_d;
  logic [SITEW-1:0] site_q, site_d;
  logic             stuck_q, stuck_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic             detected_q, detected_d;
  logic [WIDTH-1:0] firstPat_q, firstPat_d;
  logic [WIDTH:0]   detCount_q, detCount_d;
  logic [COVW-1:0]  covCount_q, covCount_d;

  logic [SITEW-1:0] injSite;
  logic             injVal;
  logic             mism;
  logic             lastPat;

  // Campaign mode walks faults site-major with stuck-0 in the low index bit.
  assign injSite = mode_q ? faultIdx_q[FIW-1:1] : site_q;
  assign injVal  = mode_q ? faultIdx_q[0] : stuck_q;

  parity_chain_inj #(.WIDTH(WIDTH), .ODD(ODD), .SITEW(SITEW)) uGolden (
    .d_i        (pat_q),
    .inj_en_i   (1'b0),
    .inj_site_i ('0),
    .inj_val_i  (1'b0),
    .p_o        (p_gold)
  );

  parity_chain_inj #(.WIDTH(WIDTH), .ODD(ODD), .SITEW(SITEW)) uFaulty (
    .d_i        (pat_q),
    .inj_en_i   (en_q),
    .inj_site_i (injSite),
    .inj_val_i  (injVal),
    .p_o        (p_fault)
  );

  assign mism    = p_gold ^ p_fault;
  assign lastPat = (pat_q == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      faultIdx_q <= '0;
      hit_q      <= 1'b0;
      mode_q     <= 1'b0;
      site_q     <= '0;
      stuck_q    <= 1'b0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      detected_q <= 1'b0;
      firstPat_q <= '0;
      detCount_q <= '0;
      covCount_q <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      faultIdx_q <= faultIdx_d;
      hit_q      <= hit_d;
      mode_q     <= mode_d;
      site_q     <= site_d;
      stuck_q    <= stuck_d;
      en_q       <= en_d;
      err_q      <= err_d;
      detected_q <= detected_d;
      firstPat_q <= firstPat_d;
      detCount_q <= detCount_d;
      covCount_q <= covCount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    faultIdx_d = faultIdx_q;
    hit_d      = hit_q;
    mode_d     = mode_q;
    site_d     = site_q;
    stuck_d    = stuck_q;
    en_d       = en_q;
    err_d      = err_q;
    detected_d = detected_q;
    firstPat_d = firstPat_q;
    detCount_d = detCount_q;
    covCount_d = covCount_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!mode && int'(site_sel) >= NSITE) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d      = 1'b0;
            detected_d = 1'b0;
            firstPat_d = '0;
            detCount_d = '0;
            covCount_d = '0;
            pat_d      = '0;
            faultIdx_d = '0;
            hit_d      = 1'b0;
            mode_d     = mode;
            site_d     = site_sel;
            stuck_d    = stuck_val;
            en_d       = fault_en;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!mode_q) begin
          if (mism) begin
            detected_d = 1'b1;
            detCount_d = detCount_q + 1'b1;
            if (!detected_q) begin
              firstPat_d = pat_q;
            end
          end
          if (lastPat) begin
            state_d = ST_DONE;
          end else begin
            pat_d = pat_q + 1'b1;
          end
        end else begin
          // The pattern counter wraps into the next fault; it freezes on the final one.
          pat_d = pat_q + 1'b1;
          if (mism) begin
            hit_d = 1'b1;
          end
          if (lastPat) begin
            if (hit_q || mism) begin
              covCount_d = covCount_q + 1'b1;
            end
            hit_d = 1'b0;
            if (faultIdx_q == FIW'(2 * NSITE - 1)) begin
              pat_d   = pat_q;
              state_d = ST_DONE;
            end else begin
              faultIdx_d = faultIdx_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign detected  = detected_q;
  assign first_pat = firstPat_q;
  assign det_count = detCount_q;
  assign cov_count = covCount_q;
  assign pat_out   = pat_q;

endmodule

// File: tb/tb_parity_fault_bist.sv
// Scoreboard bench for parity_fault_bist at WIDTH=3, even parity.
// Expected results come from a gate-level reference of the 3-bit chain with stuck-at sites.
module tb_parity_fault_bist;

  localparam int WIDTH = 3;
  localparam int NSITE = 5;
  localparam int SITEW = 3;
  localparam int COVW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [SITEW-1:0] site_sel = '0;
  logic             stuck_val = 1'b0;
  logic             fault_en = 1'b0;
  logic             busy, done, err, detected, p_gold, p_fault;
  logic [WIDTH-1:0] first_pat, pat_out;
  logic [WIDTH:0]   det_count;
  logic [COVW-1:0]  cov_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit         det;
    logic [2:0] first;
    logic [3:0] cnt;
    logic [3:0] cov;
    bit         err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] patLog[$];
  logic       goldLog[$];
  logic       faultLog[$];

  bit         obsDet, obsErr, busySeen, timedOut, doneAfter;
  logic [2:0] obsFirst;
  logic [3:0] obsCnt, obsCov;
  int         obsLat;

  parity_fault_bist #(.WIDTH(WIDTH), .ODD(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .site_sel  (site_sel),
    .stuck_val (stuck_val),
    .fault_en  (fault_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .detected  (detected),
    .first_pat (first_pat),
    .det_count (det_count),
    .cov_count (cov_count),
    .pat_out   (pat_out),
    .p_gold    (p_gold),
    .p_fault   (p_fault)
  );

  always #5 clk = ~clk;

  // Sites: 0..2 inputs d0..d2, 3 is w1 = d0^d1, 4 is the parity output.
  function automatic logic refPar(input logic [2:0] pat, input bit en, input int site, input bit val);
    logic d0, d1, d2, w1, p;
    d0 = pat[0];
    d1 = pat[1];
    d2 = pat[2];
    if (en && site == 0) d0 = val;
    if (en && site == 1) d1 = val;
    if (en && site == 2) d2 = val;
    w1 = d0 ^ d1;
    if (en && site == 3) w1 = val;
    p = w1 ^ d2;
    if (en && site == 4) p = val;
    return p;
  endfunction

  function automatic exp_t model(input bit m, input int site, input bit val, input bit en);
    exp_t e;
    bit   hit;
    e.det = 0; e.first = '0; e.cnt = '0; e.cov = '0; e.err = 0; e.lat = 0;
    if (!m && site >= NSITE) begin
      e.err = 1;
      return e;
    end
    if (!m) begin
      for (int p = 0; p < 8; p++) begin
        if (refPar(3'(p), 0, 0, 0) != refPar(3'(p), en, site, val)) begin
          if (!e.det) e.first = 3'(p);
          e.det = 1;
          e.cnt = e.cnt + 1'b1;
        end
      end
      e.lat = 8;
    end else begin
      for (int f = 0; f < 2 * NSITE; f++) begin
        hit = 0;
        for (int p = 0; p < 8; p++) begin
          if (refPar(3'(p), 0, 0, 0) != refPar(3'(p), en, f / 2, f[0])) hit = 1;
        end
        if (hit) e.cov = e.cov + 1'b1;
      end
      e.lat = 2 * NSITE * 8;
    end
    return e;
  endfunction

  // Drives one start and captures results at the done cycle; comparisons live in the tests.
  task automatic launch(input bit m, input logic [2:0] site, input bit val, input bit en);
    int edges;
    bit seen;
    patLog.delete();
    goldLog.delete();
    faultLog.delete();
    busySeen = 0;
    @(negedge clk);
    mode = m; site_sel = site; stuck_val = val; fault_en = en; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    seen = 0;
    while (!seen && edges < 2000) begin
      if (busy) begin
        busySeen = 1;
        patLog.push_back(pat_out);
        goldLog.push_back(p_gold);
        faultLog.push_back(p_fault);
      end
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    timedOut = !seen;
    obsLat = edges;
    obsDet = detected; obsFirst = first_pat; obsCnt = det_count;
    obsCov = cov_count; obsErr = err;
    @(posedge clk);
    #1 doneAfter = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, err, detected} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, err, detected});
    end
    compared++;
    if ({first_pat, det_count, cov_count, pat_out} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got %h expected 0", {first_pat, det_count, cov_count, pat_out});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mode0_case(input logic [2:0] site, input bit val, input bit en, input string tag);
    exp_t e;
    sb.push_back(model(0, int'(site), val, en));
    launch(0, site, val, en);
    e = sb.pop_front();
    compared++;
    if (timedOut) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: no done within budget", tag);
    end
    compared++;
    if (obsDet !== e.det) begin
      mismatched++;
      $display("[TB] FAIL %s_detected: got %0d expected %0d", tag, obsDet, e.det);
    end
    compared++;
    if (obsFirst !== e.first) begin
      mismatched++;
      $display("[TB] FAIL %s_first_pat: got %0d expected %0d", tag, obsFirst, e.first);
    end
    compared++;
    if (obsCnt !== e.cnt) begin
      mismatched++;
      $display("[TB] FAIL %s_det_count: got %0d expected %0d", tag, obsCnt, e.cnt);
    end
    compared++;
    if (obsLat !== e.lat || obsErr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: got %0d err %0d expected %0d err 0", tag, obsLat, obsErr, e.lat);
    end
    compared++;
    if (doneAfter !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_done_pulse: done still %0d a cycle later, expected 0", tag, doneAfter);
    end
    compared++;
    if (patLog.size() != 8) begin
      mismatched++;
      $display("[TB] FAIL %s_run_cycles: got %0d expected 8", tag, patLog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        compared++;
        if (patLog[i] !== 3'(i) || goldLog[i] !== refPar(3'(i), 0, 0, 0) ||
            faultLog[i] !== refPar(3'(i), en, int'(site), val)) begin
          mismatched++;
          $display("[TB] FAIL %s_sweep[%0d]: got pat %0d gold %0d fault %0d expected pat %0d gold %0d fault %0d",
                   tag, i, patLog[i], goldLog[i], faultLog[i], i, refPar(3'(i), 0, 0, 0),
                   refPar(3'(i), en, int'(site), val));
        end
      end
    end
  endtask

  task automatic test_mode0();
    test_mode0_case(3'd0, 1'b0, 1'b1, "m0_site0_s0");
    test_mode0_case(3'd3, 1'b1, 1'b1, "m0_w1_s1");
    test_mode0_case(3'd4, 1'b0, 1'b0, "m0_p_noinj");
  endtask

  task automatic test_campaign(input bit en, input string tag);
    exp_t e;
    sb.push_back(model(1, 0, 0, en));
    fork
      launch(1, 3'd0, 1'b0, en);
      begin
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    join
    e = sb.pop_front();
    compared++;
    if (timedOut) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: no done within budget", tag);
    end
    compared++;
    if (obsCov !== e.cov) begin
      mismatched++;
      $display("[TB] FAIL %s_cov_count: got %0d expected %0d", tag, obsCov, e.cov);
    end
    compared++;
    if (obsLat !== e.lat) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", tag, obsLat, e.lat);
    end
    compared++;
    if (doneAfter !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_after_done: got done %0d busy %0d expected 0 0", tag, doneAfter, busy);
    end
  endtask

  task automatic test_error();
    exp_t e;
    sb.push_back(model(0, 5, 0, 1));
    launch(0, 3'd5, 1'b0, 1'b1);
    e = sb.pop_front();
    compared++;
    if (obsErr !== e.err) begin
      mismatched++;
      $display("[TB] FAIL err_flag: got %0d expected %0d", obsErr, e.err);
    end
    compared++;
    if (obsLat !== e.lat || timedOut) begin
      mismatched++;
      $display("[TB] FAIL err_latency: got %0d expected %0d", obsLat, e.lat);
    end
    compared++;
    if (busySeen) begin
      mismatched++;
      $display("[TB] FAIL err_busy: got busy 1 expected never high");
    end
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL err_hold: got %0d expected 1", err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back(model(0, 1, 1, 1));
    launch(0, 3'd1, 1'b1, 1'b1);
    e = sb.pop_front();
    compared++;
    if (obsErr !== 1'b0 || obsCnt !== e.cnt || obsFirst !== e.first || obsLat !== e.lat) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got err %0d cnt %0d first %0d lat %0d expected 0 %0d %0d %0d",
               obsErr, obsCnt, obsFirst, obsLat, e.cnt, e.first, e.lat);
    end
    sb.push_back(model(0, 2, 0, 1));
    launch(0, 3'd2, 1'b0, 1'b1);
    e = sb.pop_front();
    compared++;
    if (obsDet !== e.det || obsCnt !== e.cnt || obsFirst !== e.first || obsLat !== e.lat) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got det %0d cnt %0d first %0d lat %0d expected %0d %0d %0d %0d",
               obsDet, obsCnt, obsFirst, obsLat, e.det, e.cnt, e.first, e.lat);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit   sawDone;
    @(negedge clk);
    mode = 1'b0; site_sel = 3'd0; stuck_val = 1'b0; fault_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if ({busy, done, err, detected, p_gold, p_fault} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_flags: got %b expected 000000", {busy, done, err, detected, p_gold, p_fault});
    end
    compared++;
    if ({first_pat, det_count, cov_count, pat_out} !== '0) begin
      mismatched++;
      $display("[TB] FAIL abort_values: got %h expected 0", {first_pat, det_count, cov_count, pat_out});
    end
    @(negedge clk) rst_n = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) sawDone = 1;
    end
    compared++;
    if (sawDone) begin
      mismatched++;
      $display("[TB] FAIL abort_no_done: got done/busy activity expected none");
    end
    sb.push_back(model(0, 2, 1, 1));
    launch(0, 3'd2, 1'b1, 1'b1);
    e = sb.pop_front();
    compared++;
    if (obsDet !== e.det || obsCnt !== e.cnt || obsFirst !== e.first || obsLat !== e.lat || timedOut) begin
      mismatched++;
      $display("[TB] FAIL abort_rerun: got det %0d cnt %0d first %0d lat %0d expected %0d %0d %0d %0d",
               obsDet, obsCnt, obsFirst, obsLat, e.det, e.cnt, e.first, e.lat);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_mode0();
    test_campaign(1'b1, "m1_inject");
    test_campaign(1'b0, "m1_noinj");
    test_error();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
